// File: rtl/mem_block_mover_if.sv
// Host request and byte-wide RAM port bundle for the block mover.
// master is the mover side; slave is the host/RAM side.
interface mem_block_mover_if #(
  parameter int unsigned LEN_W = 8
);
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  // Request side, latched by the mover on an accepted start.
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  length;
  logic [DATA_W-1:0] fill_value;
  logic              busy;
  logic              done;

  // RAM side; mem_data_in is combinational from mem_address.
  logic [ADDR_W-1:0] mem_address;
  logic              mem_write_en;
  logic [DATA_W-1:0] mem_data_out;
  logic [DATA_W-1:0] mem_data_in;

  modport master (
    input  start, mode, src_addr, dst_addr, length, fill_value, mem_data_in,
    output mem_address, mem_write_en, mem_data_out, busy, done
  );

  modport slave (
    output start, mode, src_addr, dst_addr, length, fill_value, mem_data_in,
    input  mem_address, mem_write_en, mem_data_out, busy, done
  );
endinterface

// File: rtl/mem_block_mover.sv
// Block copy / block fill initiator for the byte-wide RAM port.
// Copy alternates READ/WRITE per byte; fill issues back-to-back WRITEs.
module mem_block_mover #(
  parameter int unsigned LEN_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  mem_block_mover_if.master bus
);
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] src_ptr_q;
  logic [ADDR_W-1:0] dst_ptr_q;
  logic [LEN_W-1:0]  remaining_q;
  logic [DATA_W-1:0] data_q;
  logic              mode_q;

  logic [ADDR_W-1:0] mem_address_q;
  logic              mem_write_en_q;
  logic [DATA_W-1:0] mem_data_out_q;
  logic              busy_q;
  logic              done_q;

  assign bus.mem_address  = mem_address_q;
  assign bus.mem_write_en = mem_write_en_q;
  assign bus.mem_data_out = mem_data_out_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

  // Outputs are loaded together with the state they belong to, so each
  // state's bus values appear during the cycle that state is held.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      src_ptr_q      <= '0;
      dst_ptr_q      <= '0;
      remaining_q    <= '0;
      data_q         <= '0;
      mode_q         <= 1'b0;
      mem_address_q  <= '0;
      mem_write_en_q <= 1'b0;
      mem_data_out_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      mem_address_q  <= '0;
      mem_write_en_q <= 1'b0;
      mem_data_out_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            mode_q      <= bus.mode;
            src_ptr_q   <= bus.src_addr;
            dst_ptr_q   <= bus.dst_addr;
            remaining_q <= bus.length;
            if (bus.length == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (!bus.mode) begin
              state_q       <= READ;
              mem_address_q <= bus.src_addr;
              busy_q        <= 1'b1;
            end else begin
              state_q        <= WRITE;
              data_q         <= bus.fill_value;
              mem_address_q  <= bus.dst_addr;
              mem_write_en_q <= 1'b1;
              mem_data_out_q <= bus.fill_value;
              busy_q         <= 1'b1;
            end
          end
        end

        READ: begin
          data_q         <= bus.mem_data_in;
          state_q        <= WRITE;
          mem_address_q  <= dst_ptr_q;
          mem_write_en_q <= 1'b1;
          mem_data_out_q <= bus.mem_data_in;
          busy_q         <= 1'b1;
        end

        WRITE: begin
          dst_ptr_q   <= dst_ptr_q + ADDR_W'(1);
          remaining_q <= remaining_q - LEN_W'(1);
          if (!mode_q) begin
            src_ptr_q <= src_ptr_q + ADDR_W'(1);
          end
          // Last byte: remaining reaches zero here and never wraps.
          if (remaining_q == LEN_W'(1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (!mode_q) begin
            state_q       <= READ;
            mem_address_q <= src_ptr_q + ADDR_W'(1);
            busy_q        <= 1'b1;
          end else begin
            state_q        <= WRITE;
            mem_address_q  <= dst_ptr_q + ADDR_W'(1);
            mem_write_en_q <= 1'b1;
            mem_data_out_q <= data_q;
            busy_q         <= 1'b1;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/mem_block_mover.md
Name: mem_block_mover

Overview:
- Bus initiator that drives the byte-wide RAM interface (16-bit address, async read data, write enable, write data) used by the CPU memory block.
- Performs block copy (src -> dst) or block fill (constant -> dst) of up to 2^LEN_W-1 bytes without CPU involvement.
- Sits beside the CPU on the memory port, behind an external arbiter. Loader/test harness uses it to initialise and clear the writable page (FF00-FFFF).

Parameters:
- LEN_W, 8, width of the length field; maximum transfer is 2^LEN_W-1 bytes.

Ports:
- clock  in  1  system clock, all state changes on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clock
- start  in  1  request pulse; sampled only in IDLE
- mode  in  1  0 = copy, 1 = fill; latched at start
- src_addr  in  16  copy source base address; latched at start
- dst_addr  in  16  destination base address; latched at start
- length  in  LEN_W  byte count; latched at start
- fill_value  in  8  fill byte; latched at start
- mem_data_in  in  8  RAM read data, combinational from mem_address
- mem_address  out  16  RAM address
- mem_write_en  out  1  RAM write strobe; RAM writes on rising edge while high
- mem_data_out  out  8  RAM write data
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- States: IDLE, READ, WRITE, DONE. Registers: src_ptr, dst_ptr (16b), remaining (LEN_W), data_reg (8b), mode_reg.
- Reset (any state, including mid-transfer): next state IDLE; all pointers, remaining and data_reg cleared to 0.
  - Outputs after the reset edge: mem_address=0000, mem_write_en=0, mem_data_out=00, busy=0, done=0.
  - No further writes issue from an aborted transfer.
- IDLE:
  - mem_address=0000, mem_write_en=0, busy=0.
  - On start=1 at an edge: latch all inputs.
  - length=0 -> DONE; no memory access.
  - Otherwise copy -> READ, fill -> WRITE (data_reg=fill_value).
- READ:
  - mem_address=src_ptr, mem_write_en=0, busy=1.
  - At edge: data_reg<=mem_data_in; next state WRITE.
- WRITE:
  - mem_address=dst_ptr, mem_data_out=data_reg, mem_write_en=1, busy=1.
  - At edge: dst_ptr+1, src_ptr+1 (copy only), remaining-1.
  - If remaining was 1 -> DONE; else copy -> READ, fill -> WRITE.
- DONE: done=1, busy=0, mem_write_en=0; next state IDLE unconditionally.
- Outputs are decoded from state and registers (Moore); mem_write_en is never high outside WRITE.
- mem_data_out=00 outside WRITE.
- Latency from the start edge to the done-high cycle:
  - copy: 2N cycles of access, done in the cycle after the last WRITE;
  - fill: N cycles of access, then done;
  - length=0: done in the cycle immediately after the start edge.
- Pointer arithmetic is modulo 2^16: FFFF increments to 0000.
- remaining never underflows; a zero count never enters READ or WRITE.
- start while busy or in DONE is ignored and not queued. Inputs other than start are don't-care after latching.
- Overlapping copy is a forward byte-by-byte copy with no memmove semantics. When dst_ptr is in (src, src+N), already-written bytes are re-read; this is defined behaviour, not an error.
- The block does not filter addresses. Writes outside the RAM's writable page are issued, and the memory drops them.

Test Plan:
- Copy: RAM FF10..FF13 = 11 22 33 44; start, mode=0, src=FF10, dst=FF80, len=4 -> FF80..FF83 = 11 22 33 44; exactly 4 mem_write_en cycles; done 9 cycles after the start edge; busy high for 8 cycles.
- Fill: mode=1, dst=FF20, len=3, fill=A5 -> FF20..FF22 = A5, FF23 unchanged; write addresses FF20, FF21, FF22 on consecutive cycles; done on the 4th cycle.
- Zero length and busy start: len=0 -> done pulses in the next cycle, no write_en, busy stays 0. Then a start pulse mid-transfer with different src/dst -> no effect; the original transfer completes unchanged.
- Wrap: fill, dst=FFFE, len=3, fill=5A -> write addresses FFFE, FFFF, 0000 in order; RAM FFFE/FFFF = 5A; the 0000 write is dropped by memory.
- Reset mid-op: copy of len=8 started, reset asserted during the 3rd WRITE cycle -> after the reset edge mem_write_en=0, busy=0, done never pulses; only the first 2 (or 3 if written on that edge) destination bytes change.
- Overlap: FF40..FF42 = 01 02 03, copy src=FF40, dst=FF41, len=2 -> FF41=01, FF42=01.
